// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// uart_rx_ext : 16x-oversampled UART receiver, runtime parity/stop select
// Rev 1.0
// ============================================================================
module uart_rx_ext #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_en,
  input  logic           rx_data,
  input  logic           parity_en,
  input  logic           parity_odd,
  input  logic           two_stop,
  output logic [D_W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overrun,
  output logic           busy
);

  localparam int TC_W = $clog2(B_TICK);
  localparam int BC_W = $clog2(D_W);
  localparam int MID  = B_TICK / 2;

  localparam logic [TC_W-1:0] C_TC_S0   = TC_W'(MID - 1);
  localparam logic [TC_W-1:0] C_TC_S1   = TC_W'(MID);
  localparam logic [TC_W-1:0] C_TC_DEC  = TC_W'(MID + 1);
  localparam logic [TC_W-1:0] C_TC_LAST = TC_W'(B_TICK - 1);
  localparam logic [BC_W-1:0] C_BC_LAST = BC_W'(D_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            rxs_q;
  logic [TC_W-1:0] tc_q;
  logic [BC_W-1:0] bc_q;
  logic            armed_q;
  logic            s0_q;
  logic            s1_q;
  logic [D_W-1:0]  shreg_q;
  logic            par_q;
  logic            perr_q;
  logic            ferr_q;
  logic            pen_q;
  logic            podd_q;
  logic            two_q;
  logic [D_W-1:0]  out_data_q;
  logic            out_valid_q;
  logic            perr_out_q;
  logic            ferr_out_q;
  logic            overrun_q;
  logic            busy_q;

  logic maj_d;
  logic dec_d;
  logic last_d;
  logic ferr_d;
  logic done_d;
  logic take_d;

  // The third sample is the live line at the decision tick itself.
  assign maj_d  = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign dec_d  = baud_en && (tc_q == C_TC_DEC);
  assign last_d = baud_en && (tc_q == C_TC_LAST);
  assign ferr_d = ferr_q | ~maj_d;
  assign done_d = dec_d && (((state_q == S_STOP) && !two_q) || (state_q == S_STOP2));
  assign take_d = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      tc_q        <= '0;
      bc_q        <= '0;
      armed_q     <= 1'b0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      two_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q   <= rx_data;
      rxs_q     <= sync1_q;
      overrun_q <= 1'b0;

      if (baud_en && (tc_q == C_TC_S0)) s0_q <= rxs_q;
      if (baud_en && (tc_q == C_TC_S1)) s1_q <= rxs_q;

      case (state_q)
        S_IDLE: begin
          if (rxs_q) armed_q <= 1'b1;
          if (!rxs_q && armed_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            armed_q <= 1'b0;
            tc_q    <= '0;
            pen_q   <= parity_en;
            podd_q  <= parity_odd;
            two_q   <= two_stop;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (baud_en) begin
            if (dec_d && maj_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              tc_q    <= '0;
            end else if (last_d) begin
              state_q <= S_DATA;
              tc_q    <= '0;
              bc_q    <= '0;
            end else begin
              tc_q <= tc_q + TC_W'(1);
            end
          end
        end
        S_DATA: begin
          if (dec_d) shreg_q <= {maj_d, shreg_q[D_W-1:1]};
          if (last_d) begin
            tc_q <= '0;
            if (bc_q == C_BC_LAST) state_q <= pen_q ? S_PARITY : S_STOP;
            else bc_q <= bc_q + BC_W'(1);
          end else if (baud_en) begin
            tc_q <= tc_q + TC_W'(1);
          end
        end
        S_PARITY: begin
          if (dec_d) par_q <= maj_d;
          if (last_d) begin
            perr_q  <= ((^shreg_q) ^ par_q) != podd_q;
            state_q <= S_STOP;
            tc_q    <= '0;
          end else if (baud_en) begin
            tc_q <= tc_q + TC_W'(1);
          end
        end
        S_STOP: begin
          if (dec_d) ferr_q <= ferr_d;
          if (done_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tc_q    <= '0;
          end else if (last_d) begin
            state_q <= S_STOP2;
            tc_q    <= '0;
          end else if (baud_en) begin
            tc_q <= tc_q + TC_W'(1);
          end
        end
        S_STOP2: begin
          if (dec_d) ferr_q <= ferr_d;
          if (done_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tc_q    <= '0;
          end else if (baud_en) begin
            tc_q <= tc_q + TC_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          tc_q    <= '0;
        end
      endcase

      // A completing word wins over the handshake drop so valid stays high.
      if (done_d) begin
        if (take_d) begin
          out_data_q  <= shreg_q;
          perr_out_q  <= perr_q;
          ferr_out_q  <= ferr_d;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ext : directed self-checking bench for uart_rx_ext
// Rev 1.0
// ============================================================================
module tb_uart_rx_ext;

  localparam int D_W     = 8;
  localparam int B_TICK  = 16;
  localparam int DIV     = 4;
  localparam int BIT_CLK = B_TICK * DIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           baud_en = 1'b0;
  logic           rx_data = 1'b1;
  logic           parity_en = 1'b0;
  logic           parity_odd = 1'b0;
  logic           two_stop = 1'b0;
  logic           out_ready = 1'b1;
  logic [D_W-1:0] out_data;
  logic           out_valid;
  logic           parity_err;
  logic           frame_err;
  logic           overrun;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int n_words = 0;
  int n_ovr = 0;
  int n_busy = 0;
  logic [D_W-1:0] cap_data = '0;
  logic           cap_perr = 1'b0;
  logic           cap_ferr = 1'b0;
  logic           busy_prev = 1'b0;

  uart_rx_ext #(.D_W(D_W), .B_TICK(B_TICK)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_en    (baud_en),
    .rx_data    (rx_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      bcnt    = (bcnt == DIV - 1) ? 0 : bcnt + 1;
      baud_en = (bcnt == 0);
    end
  end

  // Word/event recorder sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_words  = n_words + 1;
        cap_data = out_data;
        cap_perr = parity_err;
        cap_ferr = frame_err;
      end
      if (overrun) n_ovr = n_ovr + 1;
      if (busy && !busy_prev) n_busy = n_busy + 1;
    end
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_time(input logic v);
    rx_data = v;
    tick(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop1, input logic has_s2, input logic stop2);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (has_par) bit_time(pbit);
    bit_time(stop1);
    if (has_s2) bit_time(stop2);
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits; i++) bit_time(1'b1);
  endtask

  initial begin
    int w0;
    int o0;
    int b0;

    tick(5);
    rst = 1'b0;
    tick(3);
    chk("rst_data",    32'(out_data),   32'h0);
    chk("rst_valid",   32'(out_valid),  32'h0);
    chk("rst_perr",    32'(parity_err), 32'h0);
    chk("rst_ferr",    32'(frame_err),  32'h0);
    chk("rst_overrun", 32'(overrun),    32'h0);
    chk("rst_busy",    32'(busy),       32'h0);
    idle(1);

    // 8N1 0x55
    w0 = n_words;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("8n1_count", 32'(n_words - w0), 32'd1);
    chk("8n1_data",  32'(cap_data), 32'h55);
    chk("8n1_perr",  32'(cap_perr), 32'h0);
    chk("8n1_ferr",  32'(cap_ferr), 32'h0);

    // 8E1 0xA5, correct parity then wrong parity
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("8e1_data", 32'(cap_data), 32'hA5);
    chk("8e1_perr", 32'(cap_perr), 32'h0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("8e1_bad_perr", 32'(cap_perr), 32'h1);
    parity_odd = 1'b1;
    w0 = n_words;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("8o1_count", 32'(n_words - w0), 32'd1);
    chk("8o1_perr",  32'(cap_perr), 32'h0);
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // Framing error followed by a held break
    w0 = n_words;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    chk("frm_count", 32'(n_words - w0), 32'd1);
    chk("frm_data",  32'(cap_data), 32'h3C);
    chk("frm_ferr",  32'(cap_ferr), 32'h1);
    idle(2);
    chk("frm_no_retrig", 32'(n_words - w0), 32'd1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("frm_next_count", 32'(n_words - w0), 32'd2);
    chk("frm_next_data",  32'(cap_data), 32'hC3);
    chk("frm_next_ferr",  32'(cap_ferr), 32'h0);

    // Start glitch of three oversample ticks
    w0 = n_words;
    b0 = n_busy;
    rx_data = 1'b0;
    tick(3 * DIV);
    idle(2);
    chk("glitch_busy_pulse", 32'(n_busy - b0), 32'd1);
    chk("glitch_busy_low",   32'(busy), 32'h0);
    chk("glitch_no_word",    32'(n_words - w0), 32'd0);

    // Overrun with consumer stalled
    out_ready = 1'b0;
    w0 = n_words;
    o0 = n_ovr;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("ovr_valid", 32'(out_valid), 32'h1);
    chk("ovr_data",  32'(out_data), 32'h11);
    chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
    out_ready = 1'b1;
    tick(1);
    chk("ovr_drop",     32'(out_valid), 32'h0);
    chk("ovr_xfer",     32'(n_words - w0), 32'd1);
    chk("ovr_xfer_dat", 32'(cap_data), 32'h11);
    idle(1);

    // Reset mid-DATA with a word held
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rx_data = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_valid", 32'(out_valid),  32'h0);
    chk("mid_rst_data",  32'(out_data),   32'h0);
    chk("mid_rst_busy",  32'(busy),       32'h0);
    chk("mid_rst_ferr",  32'(frame_err),  32'h0);
    chk("mid_rst_perr",  32'(parity_err), 32'h0);
    idle(2);

    // Two stop bits, second one low
    out_ready = 1'b1;
    two_stop = 1'b1;
    w0 = n_words;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("2stop_count", 32'(n_words - w0), 32'd1);
    chk("2stop_data",  32'(cap_data), 32'h81);
    chk("2stop_ferr",  32'(cap_ferr), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
